// File: rtl/async_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : async_req_arbiter
// Purpose  : Four-requester round-robin arbiter for asynchronous requests.
//            Each request bit passes through its own two-flop synchronizer.
//            A three-state FSM (IDLE/GRANT/RELEASE) produces a registered
//            one-hot grant.
// Options  : `define SYNC_ARB_TIMEOUT_EN enables a forced release after
//            TIMEOUT_CYCLES cycles in GRANT, signalled by a one-cycle pulse
//            on the timeout output.
// Revision : 1.0 - initial release
// ============================================================================
module async_req_arbiter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [3:0] async_req,
  input  logic       done,
  output logic [3:0] grant,
  output logic [1:0] grant_id,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] sync1;
  logic [3:0] sreq;
  logic [1:0] ptr;
  logic       win_found;
  logic [1:0] win_id;

  // Two-flop synchronizer per request bit; only sreq is used downstream
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1 <= 4'b0000;
      sreq  <= 4'b0000;
    end else begin
      sync1 <= async_req;
      sreq  <= sync1;
    end
  end

  // Round-robin pick: first synchronized request at or after ptr, wrapping 3->0
  always_comb begin
    logic [1:0] idx;
    win_found = 1'b0;
    win_id    = ptr;
    idx       = ptr;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!win_found && sreq[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
  end

`ifdef SYNC_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
`else
  // No forced release in this build; the expression is constant zero
  assign timeout = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

  // Arbitration FSM with registered grant, grant_id, busy and timeout
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      grant    <= 4'b0000;
      grant_id <= 2'd0;
      busy     <= 1'b0;
      ptr      <= 2'd0;
`ifdef SYNC_ARB_TIMEOUT_EN
      timeout  <= 1'b0;
      cnt      <= '0;
`endif
    end else begin
`ifdef SYNC_ARB_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      case (state)
        IDLE: begin
          grant <= 4'b0000;
          if (win_found) begin
            grant    <= 4'b0001 << win_id;
            grant_id <= win_id;
            busy     <= 1'b1;
            state    <= GRANT;
`ifdef SYNC_ARB_TIMEOUT_EN
            cnt      <= '0;
`endif
          end
        end
        GRANT: begin
          // done takes priority over an abandon seen in the same cycle
          if (done) begin
            grant <= 4'b0000;
            ptr   <= grant_id + 2'd1;
            state <= RELEASE;
          end else if (!sreq[grant_id]) begin
            grant <= 4'b0000;
            busy  <= 1'b0;
            ptr   <= grant_id + 2'd1;
            state <= IDLE;
          end
`ifdef SYNC_ARB_TIMEOUT_EN
          else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            grant   <= 4'b0000;
            timeout <= 1'b1;
            ptr     <= grant_id + 2'd1;
            state   <= RELEASE;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        RELEASE: begin
          // Hold off until the finished owner withdraws its request
          grant <= 4'b0000;
          if (!sreq[grant_id]) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          grant <= 4'b0000;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
